// File: rtl/usb_rx_bit_sampler.sv
// USB receive bit sampler: recovers bit timing from D+ transitions, NRZI-decodes
// the sampled line, removes stuffed zeros and flags SE0 and stuffing violations.
module usb_rx_bit_sampler #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned SAMPLE_PT    = 3,
    parameter int unsigned STUFF_LEN    = 6
) (
    input  logic clk,
    input  logic n_rst,
    input  logic rcving,
    input  logic d_plus,
    input  logic d_minus,
    output logic shift_enable,
    output logic d_orig,
    output logic eop,
    output logic bit_stuff_err
);

    localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned ONES_W = 3;

    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_SMP = CNT_W'(SAMPLE_PT);
    localparam logic [ONES_W-1:0] STUFF_N = ONES_W'(STUFF_LEN);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ONES_W-1:0] ones_q, ones_d;
    logic              last_q, last_d;
    logic              dp_prev_q;
    logic              se_q, se_d;
    logic              dorig_q, dorig_d;
    logic              eop_q, eop_d;
    logic              err_q, err_d;

    logic line_edge_c;
    logic strobe_c;
    logic se0_c;
    logic bit_c;

    // Line observation: a D+ transition resynchronises the phase and wins over the strobe.
    always_comb begin
        line_edge_c = rcving && (d_plus != dp_prev_q);
        strobe_c    = rcving && !line_edge_c && (cnt_q == CNT_SMP);
        se0_c       = !d_plus && !d_minus;
        bit_c       = (d_plus == last_q);
    end

    always_comb begin
        cnt_d   = cnt_q;
        ones_d  = ones_q;
        last_d  = last_q;
        se_d    = 1'b0;
        dorig_d = dorig_q;
        eop_d   = 1'b0;
        err_d   = 1'b0;

        if (!rcving) begin
            cnt_d   = '0;
            ones_d  = '0;
            last_d  = 1'b1;
            dorig_d = 1'b1;
        end else begin
            if (line_edge_c || (cnt_q == CNT_MAX)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            if (strobe_c) begin
                if (se0_c) begin
                    eop_d  = 1'b1;
                    ones_d = '0;
                    last_d = 1'b1;
                end else begin
                    last_d = d_plus;
                    if (ones_q < STUFF_N) begin
                        se_d    = 1'b1;
                        dorig_d = bit_c;
                        ones_d  = bit_c ? (ones_q + ONES_W'(1)) : '0;
                    end else begin
                        // A full run of ones: a zero here is stuffing, a one is a violation.
                        err_d  = bit_c;
                        ones_d = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt_q     <= '0;
            ones_q    <= '0;
            last_q    <= 1'b1;
            dp_prev_q <= 1'b1;
            se_q      <= 1'b0;
            dorig_q   <= 1'b1;
            eop_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            ones_q    <= ones_d;
            last_q    <= last_d;
            dp_prev_q <= d_plus;
            se_q      <= se_d;
            dorig_q   <= dorig_d;
            eop_q     <= eop_d;
            err_q     <= err_d;
        end
    end

    assign shift_enable  = se_q;
    assign d_orig        = dorig_q;
    assign eop           = eop_q;
    assign bit_stuff_err = err_q;

endmodule

// File: tb/tb_usb_rx_bit_sampler.sv
// Bench for usb_rx_bit_sampler: directed USB line sequences plus random line
// traffic, every cycle compared against a time-based reference model.
module tb_usb_rx_bit_sampler;

    localparam int unsigned CLKS  = 8;
    localparam int unsigned SMP   = 3;
    localparam int          STUFF = 6;

    logic clk = 1'b0;
    logic n_rst, rcving, d_plus, d_minus;
    logic shift_enable, d_orig, eop, bit_stuff_err;

    always #5 clk = ~clk;

    usb_rx_bit_sampler #(
        .CLKS_PER_BIT (CLKS),
        .SAMPLE_PT    (SMP),
        .STUFF_LEN    (STUFF)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .rcving        (rcving),
        .d_plus        (d_plus),
        .d_minus       (d_minus),
        .shift_enable  (shift_enable),
        .d_orig        (d_orig),
        .eop           (eop),
        .bit_stuff_err (bit_stuff_err)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the sampling phase is time elapsed since the last anchor
    // (reset, receiver idle, or a D+ transition), modulo the bit period.
    int unsigned cyc    = 0;
    int unsigned anchor = 0;
    logic m_prev = 1'b1;
    logic m_last = 1'b1;
    int   m_run  = 0;
    logic e_se = 1'b0, e_do = 1'b1, e_eop = 1'b0, e_err = 1'b0;

    task automatic model_step(input logic rst, input logic rc, input logic dp, input logic dm);
        int unsigned phase;
        logic tr, sample, b;
        cyc++;
        e_se  = 1'b0;
        e_eop = 1'b0;
        e_err = 1'b0;
        if (!rst) begin
            anchor = cyc;
            m_prev = 1'b1;
            m_last = 1'b1;
            m_run  = 0;
            e_do   = 1'b1;
        end else begin
            tr     = rc && (dp != m_prev);
            phase  = (cyc - 1 - anchor) % CLKS;
            sample = rc && !tr && (phase == SMP);
            if (!rc) begin
                anchor = cyc;
                m_run  = 0;
                m_last = 1'b1;
                e_do   = 1'b1;
            end else if (tr) begin
                anchor = cyc;
            end
            if (sample) begin
                if (!dp && !dm) begin
                    e_eop  = 1'b1;
                    m_run  = 0;
                    m_last = 1'b1;
                end else begin
                    b      = (dp == m_last);
                    m_last = dp;
                    if (m_run < STUFF) begin
                        e_se  = 1'b1;
                        e_do  = b;
                        m_run = b ? m_run + 1 : 0;
                    end else begin
                        e_err = b;
                        m_run = 0;
                    end
                end
            end
            m_prev = dp;
        end
    endtask

    logic pulses[$];
    int   n_eop = 0;
    int   n_err = 0;
    logic cur_dp = 1'b1;

    task automatic tick(input logic rst, input logic rc, input logic dp, input logic dm);
        n_rst   = rst;
        rcving  = rc;
        d_plus  = dp;
        d_minus = dm;
        model_step(rst, rc, dp, dm);
        @(negedge clk);
        chk("shift_enable", 32'(shift_enable), 32'(e_se));
        chk("d_orig", 32'(d_orig), 32'(e_do));
        chk("eop", 32'(eop), 32'(e_eop));
        chk("bit_stuff_err", 32'(bit_stuff_err), 32'(e_err));
        chk("exclusive", 32'($countones({shift_enable, eop, bit_stuff_err}) <= 1), 32'(1));
        if (shift_enable === 1'b1) pulses.push_back(d_orig);
        if (eop === 1'b1) n_eop++;
        if (bit_stuff_err === 1'b1) n_err++;
    endtask

    task automatic send(input logic dp, input int nbits);
        cur_dp = dp;
        for (int i = 0; i < nbits * int'(CLKS); i++) tick(1'b1, 1'b1, dp, !dp);
    endtask

    task automatic send_se0(input int nbits);
        cur_dp = 1'b0;
        for (int i = 0; i < nbits * int'(CLKS); i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic clear_rec();
        pulses.delete();
        n_eop = 0;
        n_err = 0;
    endtask

    task automatic check_pulses(input string tag, input logic exp[$]);
        chk({tag, "_count"}, 32'(pulses.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < pulses.size(); i++)
            chk({tag, "_bit"}, 32'(pulses[i]), 32'(exp[i]));
    endtask

    task automatic send_sync();
        send(1'b0, 1); send(1'b1, 1); send(1'b0, 1); send(1'b1, 1);
        send(1'b0, 1); send(1'b1, 1); send(1'b0, 1); send(1'b0, 1);
    endtask

    logic exp_q[$];
    int unsigned r, len;
    logic rnd_rc;

    initial begin
        // Reset held over toggling lines with the receiver enabled
        clear_rec();
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        chk("reset_pulses", 32'(pulses.size() + n_eop + n_err), 32'(0));
        tick(1'b1, 1'b0, 1'b1, 1'b0);

        // Sync field
        clear_rec();
        send_sync();
        exp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        check_pulses("sync", exp_q);

        // Stuffed zero after six ones is dropped
        clear_rec();
        send(1'b1, 7);
        send(1'b0, 1);
        send(1'b1, 1);
        exp_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        check_pulses("stuff", exp_q);
        chk("stuff_err_none", 32'(n_err), 32'(0));

        // Seventh consecutive one is a stuffing violation
        clear_rec();
        send(1'b1, 7);
        exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        check_pulses("stufferr", exp_q);
        chk("stufferr_err", 32'(n_err), 32'(1));

        // EOP: two SE0 samples, then J and K
        clear_rec();
        send_se0(2);
        chk("eop_no_shift", 32'(pulses.size()), 32'(0));
        send(1'b1, 1);
        send(1'b0, 1);
        chk("eop_count", 32'(n_eop), 32'(2));
        exp_q = '{1'b1, 1'b0};
        check_pulses("after_eop", exp_q);

        // Abort mid-bit, then a fresh sync
        clear_rec();
        send(1'b1, 1); send(1'b0, 1); send(1'b1, 1);
        chk("abort_pre", 32'(pulses.size()), 32'(3));
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b1);
        clear_rec();
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 1'(i % 2), 1'(~(i % 2)));
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        chk("abort_quiet", 32'(pulses.size() + n_eop + n_err), 32'(0));
        send_sync();
        exp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        check_pulses("resync", exp_q);

        // Random line traffic with jitter, glitches, SE0, idle gaps and resets
        rnd_rc = 1'b1;
        for (int s = 0; s < 1500; s++) begin
            r   = $urandom_range(0, 99);
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : CLKS;
            if (r < 2) begin
                for (int i = 0; i < 2; i++) tick(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
            end else if (r < 7) begin
                for (int i = 0; i < int'(len); i++) tick(1'b1, 1'b0, 1'($urandom), 1'($urandom));
            end else if (r < 13) begin
                for (int i = 0; i < int'(len); i++) tick(1'b1, rnd_rc, 1'b0, 1'b0);
                cur_dp = 1'b0;
            end else begin
                if ($urandom_range(0, 1) == 0) cur_dp = 1'($urandom);
                for (int i = 0; i < int'(len); i++) tick(1'b1, rnd_rc, cur_dp, !cur_dp);
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/usb_rx_bit_sampler.md
USB_RX_BIT_SAMPLER -- requirements
Module: usb_rx_bit_sampler

Interface
REQ-001 Parameter CLKS_PER_BIT, default 8, clocks per USB bit time.
REQ-002 Parameter SAMPLE_PT, default 3, phase-counter value at which the line is sampled.
REQ-003 Parameter STUFF_LEN, default 6, consecutive decoded 1s after which a stuffed 0 is expected.
REQ-004 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-005 n_rst  input  1  reset, synchronous and active-low.
REQ-006 rcving  input  1  receive-enable from the RX controller; 0 holds the block idle.
REQ-007 d_plus  input  1  already-synchronized D+ line.
REQ-008 d_minus  input  1  already-synchronized D- line.
REQ-009 shift_enable  output  1  one-cycle pulse per accepted data bit; drives the RX shift register and the RX byte counter count_enable.
REQ-010 d_orig  output  1  NRZI-decoded bit, valid while shift_enable=1, held until next update.
REQ-011 eop  output  1  one-cycle pulse on a sampled SE0 (d_plus=0, d_minus=0).
REQ-012 bit_stuff_err  output  1  one-cycle pulse on a bit-stuffing violation.

Function
REQ-013 Edge detect: d_plus_prev SHALL register d_plus each cycle; edge = (d_plus != d_plus_prev) while rcving=1.
REQ-014 Phase counter: width ceil(log2(CLKS_PER_BIT)); on edge load 0; else increment, wrapping CLKS_PER_BIT-1 -> 0.
REQ-015 Strobe SHALL be asserted combinationally when counter==SAMPLE_PT, rcving=1, and no edge this cycle; edge takes priority.
REQ-016 All outputs SHALL be registered: strobe at rising edge k -> output pulse visible in cycle after edge k (1-cycle latency).
REQ-017 Resulting timing: transition first captured at edge k -> shift_enable high during cycle after edge k+4 (defaults).
REQ-018 At strobe with SE0: eop<=1, shift_enable<=0, ones_cnt<=0, last_level<=1 (J); d_orig unchanged.
REQ-019 At strobe with non-SE0: decoded bit = 1 if d_plus==last_level else 0; last_level<=d_plus.
REQ-020 Bit stuffing: ones_cnt (3 bits) counts consecutive decoded 1s of accepted bits.
REQ-021 ones_cnt<STUFF_LEN: bit accepted; shift_enable<=1, d_orig<=bit; ones_cnt<=bit ? ones_cnt+1 : 0.
REQ-022 ones_cnt==STUFF_LEN and bit=0: stuffed bit dropped; shift_enable<=0, ones_cnt<=0.
REQ-023 ones_cnt==STUFF_LEN and bit=1: bit_stuff_err<=1, shift_enable<=0, ones_cnt<=0.
REQ-024 Non-strobe cycles: shift_enable, eop, bit_stuff_err SHALL be 0.
REQ-025 rcving=0 (including mid-byte): counter<=0, ones_cnt<=0, last_level<=1, all pulse outputs 0 next cycle; d_orig<=1.
REQ-026 shift_enable, eop, bit_stuff_err SHALL be mutually exclusive in every cycle.
REQ-027 D- SHALL be used only for SE0 detection; J/K decoding uses d_plus.

Reset
REQ-028 On a rising edge with n_rst=0: counter=0, ones_cnt=0, last_level=1, d_plus_prev=1, shift_enable=0, d_orig=1, eop=0, bit_stuff_err=0.
REQ-029 Reset SHALL override rcving and all line activity; asynchronous deassertion of n_rst between edges SHALL have no effect.

Verification
REQ-030 Reset: hold n_rst=0 two edges with toggling lines, rcving=1 -> outputs 0/1/0/0 (shift_enable/d_orig/eop/err), no pulses.
REQ-031 Sync field: rcving=1, drive d_plus K,J,K,J,K,J,K,K (0,1,0,1,0,1,0,0), 8 clocks each -> exactly 8 shift_enable pulses, d_orig 0,0,0,0,0,0,0,1, each 4 edges after its transition capture.
REQ-032 Stuffing: after a 0, hold d_plus constant 6 bit times then toggle for 1 bit, then toggle again -> 6 pulses d_orig=1, no pulse for stuffed bit, next bit accepted with d_orig=0, ones_cnt=0.
REQ-033 Stuff error: hold d_plus constant 7 bit times after a 0 -> 6 pulses d_orig=1, then bit_stuff_err one cycle, no 7th shift_enable.
REQ-034 EOP: SE0 for 2 bit times then J -> eop pulse per SE0 sample, zero shift_enable during SE0; next K decodes as 0.
REQ-035 Abort: drop rcving after 3 accepted bits mid-bit -> no further pulses; re-raise and send sync -> decoding matches REQ-031 from last_level=1.
